// File: rtl/elixirchip_es1_spu_op_delay_pkg.sv
// Shared types and helpers for the multi-lane SPU operand delay line.
package elixirchip_es1_spu_op_delay_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    SETTLE = 1'b1
  } state_t;

  // Requests outside 1..max_latency are pinned to the nearest legal depth.
  function automatic int clamp_latency(input int requested, input int max_latency);
    if (requested < 1) begin
      return 1;
    end
    if (requested > max_latency) begin
      return max_latency;
    end
    return requested;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_delay_stage.sv
// One clock-enabled pipeline stage holding data and valid for every lane.
module elixirchip_es1_spu_op_delay_stage
  import elixirchip_es1_spu_op_delay_pkg::*;
#(
  parameter int  CHANNELS = 4,
  parameter type data_t   = logic [7:0]
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cke,
  input  logic  [CHANNELS-1:0] in_load,
  input  logic  [CHANNELS-1:0] in_valid,
  input  data_t [CHANNELS-1:0] in_data,
  output data_t [CHANNELS-1:0] out_data,
  output logic  [CHANNELS-1:0] out_valid
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      data_t data_reg;
      logic  valid_reg;

      // Data only moves on load so an idle head stage keeps its last value.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end else if (cke) begin
          valid_reg <= in_valid[gi];
          if (in_load[gi]) begin
            data_reg <= in_data[gi];
          end
        end
      end

      assign out_data[gi]  = data_reg;
      assign out_valid[gi] = valid_reg;
    end
  endgenerate

endmodule

// File: rtl/elixirchip_es1_spu_op_delay.sv
// Multi-lane run-time-selectable operand delay; output valid is masked
// until a latency change has flushed through the new depth.
module elixirchip_es1_spu_op_delay
  import elixirchip_es1_spu_op_delay_pkg::*;
#(
  parameter int    CHANNELS        = 4,
  parameter int    DATA_BITS       = 8,
  parameter type   data_t          = logic [DATA_BITS-1:0],
  parameter int    MAX_LATENCY     = 8,
  parameter int    LAT_BITS        = $clog2(MAX_LATENCY + 1),
  parameter int    DEFAULT_LATENCY = 1,
  parameter data_t CLEAR_DATA      = '0,
  parameter bit    USE_CLEAR       = 1'b1,
  parameter bit    USE_VALID       = 1'b1,
  parameter string DEVICE          = "RTL",
  parameter string SIMULATION      = "false",
  parameter string DEBUG           = "false"
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cke,
  input  logic  [LAT_BITS-1:0] latency,
  input  logic  [CHANNELS-1:0] s_clear,
  input  logic  [CHANNELS-1:0] s_valid,
  input  data_t [CHANNELS-1:0] s_data,
  output data_t [CHANNELS-1:0] m_data,
  output logic  [CHANNELS-1:0] m_valid,
  output logic                 m_settling
);

  localparam logic [LAT_BITS-1:0] DEFAULT_LAT = LAT_BITS'(DEFAULT_LATENCY);
  localparam bit CHECKS_ON = (SIMULATION == "true") || (DEBUG == "true") || (DEVICE == "SIM");

  logic  [CHANNELS-1:0] clear_eff;
  logic  [CHANNELS-1:0] valid_eff;
  logic  [CHANNELS-1:0] head_load;
  logic  [CHANNELS-1:0] head_valid;
  data_t [CHANNELS-1:0] head_data;

  data_t [CHANNELS-1:0] stage_data  [MAX_LATENCY];
  logic  [CHANNELS-1:0] stage_valid [MAX_LATENCY];

  logic  [CHANNELS-1:0] sel_valid;
  logic  [LAT_BITS-1:0] latency_clamped;
  logic  [LAT_BITS-1:0] latency_reg, latency_next;
  logic  [LAT_BITS-1:0] settle_cnt_reg, settle_cnt_next;
  state_t               state_reg, state_next;

  assign clear_eff = USE_CLEAR ? s_clear : '0;
  assign valid_eff = USE_VALID ? s_valid : '1;

  genvar gi;
  generate
    // Clear wins over valid and leaves the lane invalid.
    for (gi = 0; gi < CHANNELS; gi++) begin : g_head
      assign head_load[gi]  = clear_eff[gi] | valid_eff[gi];
      assign head_valid[gi] = ~clear_eff[gi] & valid_eff[gi];
      assign head_data[gi]  = clear_eff[gi] ? CLEAR_DATA : s_data[gi];
    end

    for (gi = 0; gi < MAX_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        elixirchip_es1_spu_op_delay_stage #(
          .CHANNELS (CHANNELS),
          .data_t   (data_t)
        ) u_stage (
          .clk       (clk),
          .reset_n   (reset_n),
          .cke       (cke),
          .in_load   (head_load),
          .in_valid  (head_valid),
          .in_data   (head_data),
          .out_data  (stage_data[gi]),
          .out_valid (stage_valid[gi])
        );
      end else begin : g_rest
        elixirchip_es1_spu_op_delay_stage #(
          .CHANNELS (CHANNELS),
          .data_t   (data_t)
        ) u_stage (
          .clk       (clk),
          .reset_n   (reset_n),
          .cke       (cke),
          .in_load   ({CHANNELS{1'b1}}),
          .in_valid  (stage_valid[gi-1]),
          .in_data   (stage_data[gi-1]),
          .out_data  (stage_data[gi]),
          .out_valid (stage_valid[gi])
        );
      end
    end
  endgenerate

  assign latency_clamped = LAT_BITS'(clamp_latency(int'(latency), MAX_LATENCY));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= RUN;
      latency_reg    <= DEFAULT_LAT;
      settle_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      latency_reg    <= latency_next;
      settle_cnt_reg <= settle_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    latency_next    = latency_reg;
    settle_cnt_next = settle_cnt_reg;
    if (cke) begin
      case (state_reg)
        RUN: begin
          if (latency_clamped != latency_reg) begin
            latency_next    = latency_clamped;
            settle_cnt_next = latency_clamped;
            state_next      = SETTLE;
          end
        end
        SETTLE: begin
          // A new request restarts the flush window at the new depth.
          if (latency_clamped != latency_reg) begin
            latency_next    = latency_clamped;
            settle_cnt_next = latency_clamped;
          end else if (settle_cnt_reg <= LAT_BITS'(1)) begin
            settle_cnt_next = '0;
            state_next      = RUN;
          end else begin
            settle_cnt_next = settle_cnt_reg - 1'b1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Output taps only registered stages, never the live inputs.
  always_comb begin
    m_data    = stage_data[0];
    sel_valid = stage_valid[0];
    for (int i = 1; i < MAX_LATENCY; i++) begin
      if (latency_reg == LAT_BITS'(i + 1)) begin
        m_data    = stage_data[i];
        sel_valid = stage_valid[i];
      end
    end
  end

  assign m_valid    = sel_valid & {CHANNELS{state_reg == RUN}};
  assign m_settling = (state_reg == SETTLE);

  generate
    if (CHECKS_ON) begin : g_checks
      always_ff @(posedge clk) begin
        if (reset_n) begin
          assert (latency_reg != '0 && latency_reg <= LAT_BITS'(MAX_LATENCY));
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_elixirchip_es1_spu_op_delay.sv
// Scoreboard bench: the driver queues expected lane outputs with their due
// cke-cycle, and a monitor pops and compares after every enabled edge.
module tb_elixirchip_es1_spu_op_delay;

  localparam int CH   = 4;
  localparam int MAXL = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            cke;
  logic [3:0]      latency;
  logic [CH-1:0]   s_clear;
  logic [CH-1:0]   s_valid;
  logic [CH-1:0][7:0] s_data;
  logic [CH-1:0][7:0] m_data;
  logic [CH-1:0]   m_valid;
  logic            m_settling;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_delay #(
    .CHANNELS        (CH),
    .DATA_BITS       (8),
    .MAX_LATENCY     (MAXL),
    .DEFAULT_LATENCY (3),
    .CLEAR_DATA      (8'hFF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cke        (cke),
    .latency    (latency),
    .s_clear    (s_clear),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_settling (m_settling)
  );

  typedef struct {
    logic [7:0] data;
    logic       valid;
    int         due;
  } exp_t;

  exp_t sb [CH][$];

  int checks   = 0;
  int errors   = 0;
  int cke_cnt  = 0;
  int lat_exp  = 3;
  int lat_req  = 3;
  int run_from = 0;

  function automatic int clamp_req(input int r);
    if (r < 1) return 1;
    if (r > MAXL) return MAXL;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One clock: check settle flag for the previous edge, then drive this one.
  task automatic cycle(input logic c, input logic [3:0] clr, input logic [3:0] vld,
                       input logic [31:0] d);
    int   cl;
    exp_t e;
    @(negedge clk);
    if (reset_n) begin
      checks++;
      if (m_settling !== (cke_cnt < run_from)) begin
        errors++;
        $display("FAIL settling: got %b want %b at cke %0d", m_settling,
                 (cke_cnt < run_from), cke_cnt);
      end
    end
    cke     = c;
    s_clear = clr;
    s_valid = vld;
    s_data  = d;
    latency = 4'(lat_req);
    if (c) begin
      cl = clamp_req(lat_req);
      if (cl != lat_exp) begin
        lat_exp  = cl;
        run_from = cke_cnt + 1 + cl;
      end
      for (int i = 0; i < CH; i++) begin
        if (clr[i] || vld[i]) begin
          e.due   = cke_cnt + lat_exp;
          e.valid = !clr[i];
          e.data  = clr[i] ? 8'hFF : d[i*8 +: 8];
          if (e.due >= run_from) sb[i].push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 4'h0, 4'h0, 32'h0);
  endtask

  // Monitor
  initial begin
    logic edge_cke, edge_rst;
    exp_t e;
    forever begin
      @(posedge clk);
      edge_cke = cke;
      edge_rst = reset_n;
      #1;
      if (edge_rst && reset_n && edge_cke) begin
        cke_cnt++;
        for (int i = 0; i < CH; i++) begin
          while (sb[i].size() > 0 && sb[i][0].due < cke_cnt) begin
            e = sb[i].pop_front();
            checks++;
            errors++;
            $display("FAIL lane%0d missing: got nothing want %h due %0d", i, e.data, e.due);
          end
          if (sb[i].size() > 0 && sb[i][0].due == cke_cnt) begin
            e = sb[i].pop_front();
            checks++;
            if (m_valid[i] !== e.valid || m_data[i] !== e.data) begin
              errors++;
              $display("FAIL lane%0d out: got v=%b d=%h want v=%b d=%h at cke %0d",
                       i, m_valid[i], m_data[i], e.valid, e.data, cke_cnt);
            end
          end else begin
            checks++;
            if (m_valid[i] !== 1'b0) begin
              errors++;
              $display("FAIL lane%0d spurious: got v=%b d=%h want v=0 at cke %0d",
                       i, m_valid[i], m_data[i], cke_cnt);
            end
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset_n = 1'b0;
    cke     = 1'b0;
    latency = 4'd3;
    s_clear = '0;
    s_valid = '0;
    s_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_m_data", 32'(m_data), 32'h0);
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_m_settling", 32'(m_settling), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Fixed latency 3 on lane 0, including all-zero and all-one data.
    cycle(1'b1, 4'h0, 4'h1, 32'h0000_0000);
    cycle(1'b1, 4'h0, 4'h1, 32'h0000_00FF);
    cycle(1'b1, 4'h0, 4'h1, 32'h0000_005A);
    idle(4);

    // Clear beats valid on lane 1; lane 2 carries data in the same cycle.
    cycle(1'b1, 4'h2, 4'h6, 32'h0044_3300);
    idle(4);

    // 3 -> 5 with traffic starting right after the change is accepted.
    lat_req = 5;
    cycle(1'b1, 4'h0, 4'h0, 32'h0);
    for (int k = 0; k < 8; k++) cycle(1'b1, 4'h0, 4'hF, $urandom);
    idle(6);

    // Request 0 clamps to 1.
    lat_req = 0;
    cycle(1'b1, 4'h0, 4'h0, 32'h0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'h0, 4'hF, $urandom);
    idle(3);

    // Request 15 clamps to 8, then traffic with cke low about 10% of cycles.
    lat_req = 15;
    cycle(1'b1, 4'h0, 4'h0, 32'h0);
    for (int k = 0; k < 40; k++)
      cycle(($urandom_range(0, 9) != 0), 4'($urandom) & 4'($urandom) & 4'($urandom),
            4'($urandom), $urandom);
    idle(10);

    // Asynchronous reset in the middle of a settle window.
    lat_req = 4;
    cycle(1'b1, 4'h0, 4'hF, 32'hA1B2_C3D4);
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'h0, 4'hF, 32'h1122_3344);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_m_data", 32'(m_data), 32'h0);
    check("async_rst_m_valid", 32'(m_valid), 32'h0);
    check("async_rst_m_settling", 32'(m_settling), 32'h0);
    for (int i = 0; i < CH; i++) sb[i].delete();
    lat_exp  = 3;
    lat_req  = 3;
    run_from = 0;
    latency  = 4'd3;
    s_valid  = '0;
    s_clear  = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Back at the default latency of 3 with no settle pending.
    cycle(1'b1, 4'h0, 4'h8, 32'hC300_0000);
    cycle(1'b1, 4'h0, 4'h9, 32'h7E00_0081);
    idle(5);

    for (int i = 0; i < CH; i++) begin
      checks++;
      if (sb[i].size() != 0) begin
        errors++;
        $display("FAIL lane%0d drain: got %0d pending want 0", i, sb[i].size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elixirchip_es1_spu_op_delay.md
# elixirchip_es1_spu_op_delay

Parametrised multi-channel successor to the single-channel SPU no-op delay. It delays `CHANNELS` independent data lanes through a clock-enable-gated register pipeline. The latency is selectable at run time (1..`MAX_LATENCY`), with per-lane clear/valid qualification and an output valid that is suppressed while a latency change settles. It sits in the SPU datapath wherever operands from ops of differing latency must be re-aligned.

## Interface
- `CHANNELS`, 4, number of independent lanes
- `DATA_BITS`, 8, lane data width
- `data_t`, `logic [DATA_BITS-1:0]`, lane data type
- `MAX_LATENCY`, 8, pipeline depth (≥1)
- `LAT_BITS`, `$clog2(MAX_LATENCY+1)`, width of latency control
- `DEFAULT_LATENCY`, 1, latency after reset (1..`MAX_LATENCY`)
- `CLEAR_DATA`, `'0`, value written by clear
- `USE_CLEAR`, 1'b1, 0 ties `s_clear` off internally
- `USE_VALID`, 1'b1, 0 treats `s_valid` as all-1
- `DEVICE` / `SIMULATION` / `DEBUG`, "RTL" / "false" / "false", codebase-standard
- `clk`  in  1  clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cke`  in  1  clock enable; when 0 every register holds
- `latency`  in  `LAT_BITS`  requested latency
- `s_clear`  in  `CHANNELS`  per-lane clear
- `s_valid`  in  `CHANNELS`  per-lane input valid
- `s_data`  in  `data_t [CHANNELS]`  per-lane input
- `m_data`  out  `data_t [CHANNELS]`  delayed data
- `m_valid`  out  `CHANNELS`  delayed valid, gated by settle
- `m_settling`  out  1  high while a latency change settles

## Operation
- Per lane, stage 0 on `cke`:
  - `s_clear` → data=`CLEAR_DATA`, valid=0. Clear has priority over valid.
  - Else `s_valid` → data=`s_data`, valid=1.
  - Else data holds, valid=0.
- Stage k (1..`MAX_LATENCY`-1) on `cke`: `stage[k] <= stage[k-1]`, data and valid.
- `latency_r` register holds the effective latency. The requested `latency` is clamped: 0→1, >`MAX_LATENCY`→`MAX_LATENCY`.
- `m_data[c] = stage[latency_r-1].data[c]`. This is a registered-stage mux with no combinational input path.
- FSM, two states:
  - `RUN`: on a `cke` cycle with clamped `latency` ≠ `latency_r`: `latency_r` ← clamped value, `settle_cnt` ← new latency, go to `SETTLE`.
  - `SETTLE`: on each `cke`, `settle_cnt` decrements. At 1→0, go to `RUN`. A further latency change in `SETTLE` reloads `latency_r` and `settle_cnt` and stays in `SETTLE`.
- `m_valid[c] = stage[latency_r-1].valid[c] & (state==RUN)`.
- `m_settling` = (state==SETTLE).
- Data keeps flowing during `SETTLE`; only valid is masked.

## Timing
- Reset (`reset_n`=0, asynchronous): all stage data=`'0`, valid=0, `latency_r`=`DEFAULT_LATENCY`, state `RUN`, `settle_cnt`=0. This gives `m_data`=0, `m_valid`=0, `m_settling`=0 immediately.
- With `cke`=1 continuously, input sampled at edge t appears on `m_data` after edge t+`latency_r`-1. That is, visible for the cycle following edge t+L-1, giving latency L cycles.
- `cke`=0 cycles are not counted: both latency and settle time are measured in `cke` cycles.
- A latency change is visible on `m_data` at the edge it is accepted. `m_valid` returns exactly L_new `cke` cycles later.
- Reset asserted mid-pipeline discards all in-flight data and any pending settle.
- Lanes are fully independent; simultaneous clear on some lanes and valid on others is legal.

## Structure
- Package `elixirchip_es1_spu_op_delay_pkg`: `state_t` enum {`RUN`, `SETTLE`} and a `clamp_latency` function.
- Sub-module `elixirchip_es1_spu_op_delay_stage`: a single `cke`-gated, reset_n stage of data plus valid for all lanes. Instantiated `MAX_LATENCY` times in a generate loop.
- The top level holds the clamp, `latency_r`, the FSM and the output mux.

## Test plan
- Reset, fixed L=3, `cke`=1: lane0 writes 0x00, 0xFF, 0x5A with valid=1 → the same values appear on `m_data[0]` with `m_valid[0]`=1 three cycles later. `m_settling`=0 throughout.
- `s_clear`=1 with `s_valid`=1 on lane1 (`CLEAR_DATA`=0xFF) → after L cycles `m_data[1]`=0xFF and `m_valid[1]`=0. Lane2 is unaffected.
- Random `cke` (10% low), L=`MAX_LATENCY`=8: the scoreboard counts only `cke` cycles and all lanes match the input sequence exactly.
- Change latency 3→5 mid-stream → `m_settling`=1 for 5 `cke` cycles, `m_valid`=0 throughout, then valid data delayed by 5.
- Request latency 0 and then 15 (`MAX_LATENCY`=8) → the effective latencies are 1 and 8 respectively.
- Deassert `reset_n` asynchronously between edges during `SETTLE` → outputs go to 0 immediately. After release, latency=`DEFAULT_LATENCY` and the state is `RUN`.
